irq_onehot_arbiter: RTL and testbench

Request-capture and arbitration stage sitting directly upstream of the 8-to-3 encoder. Latches rising edges on eight request lines, picks one pending request with round-robin fairness, and presents it as a stable one-hot vector plus enable, exactly the input form the encoder consumes. Each grant is held until the consumer acknowledges it, then cleared.

---
 rtl/irq_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/irq_onehot_arbiter.sv | 116 +++++++++++
 tb/tb_irq_onehot_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/irq_arb_pkg.sv
// Shared constants and state type for the interrupt request arbiter.
package irq_arb_pkg;

   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [0:0] {
      IDLE,
      GRANT
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of pending at or above ptr,
// wrapping from the top bit back to bit 0.
module rr_pick
   import irq_arb_pkg::*;
(
   input  logic [N-1:0]     pending,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] pos;

   // Walk N positions starting at ptr; the IDX_W-bit add wraps 7 -> 0 for free.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = ptr + IDX_W'(k);
         if (!valid && pending[pos]) begin
            valid       = 1'b1;
            idx         = pos;
            onehot[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_onehot_arbiter.sv
// Captures rising edges on the request lines, arbitrates round-robin and holds
// a one-hot grant plus enable until the consumer acknowledges it.
module irq_onehot_arbiter
   import irq_arb_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [N-1:0] a,
   output logic         enable,
   output logic [N-1:0] pending
);

   state_e           state_q, state_d;
   logic [N-1:0]     req_q;
   logic [N-1:0]     req_edge;
   logic [N-1:0]     pending_q, pending_d;
   logic [N-1:0]     clr;
   logic [N-1:0]     a_q, a_d;
   logic             enable_q, enable_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic [N-1:0]     pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   rr_pick u_rr_pick (
      .pending (pending_q),
      .ptr     (ptr_q),
      .onehot  (pick_onehot),
      .idx     (pick_idx),
      .valid   (pick_valid)
   );

   // Rising-edge events; a level held high only counts once.
   assign req_edge = req & ~req_q;

   // A fresh edge on the bit being cleared wins, so that request is not lost.
   assign pending_d = (pending_q & ~clr) | req_edge;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = GRANT;
         GRANT:   if (ack)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for grant outputs, pointer and the pending clear mask.
   always_comb begin
      a_d      = a_q;
      enable_d = enable_q;
      ptr_d    = ptr_q;
      gidx_d   = gidx_q;
      clr      = '0;
      unique case (state_q)
         IDLE: begin
            a_d      = '0;
            enable_d = 1'b0;
            if (pick_valid) begin
               a_d      = pick_onehot;
               enable_d = 1'b1;
               gidx_d   = pick_idx;
            end
         end
         GRANT: begin
            if (ack) begin
               clr      = a_q;
               ptr_d    = gidx_q + IDX_W'(1);
               a_d      = '0;
               enable_d = 1'b0;
            end
         end
         default: begin
            a_d      = '0;
            enable_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset drops any grant and discards pending requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q     <= '0;
         pending_q <= '0;
         a_q       <= '0;
         enable_q  <= 1'b0;
         ptr_q     <= '0;
         gidx_q    <= '0;
      end else begin
         req_q     <= req;
         pending_q <= pending_d;
         a_q       <= a_d;
         enable_q  <= enable_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
      end
   end

   assign a       = a_q;
   assign enable  = enable_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Bench for irq_onehot_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_irq_onehot_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       ack;
   logic [7:0] a;
   logic       enable;
   logic [7:0] pending;

   irq_onehot_arbiter dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .ack     (ack),
      .a       (a),
      .enable  (enable),
      .pending (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: granted index (-1 when none), pending set, last req.
   logic [7:0] m_prev;
   logic [7:0] m_pend;
   int         m_ptr;
   int         m_grant;

   typedef struct {
      logic [7:0] req;
      logic       ack;
      logic [7:0] a;
      logic       en;
      logic [7:0] pend;
   } vec_t;

   vec_t vecs[10];

   task automatic model_step();
      int cleared;
      cleared = -1;
      if (rst) begin
         m_prev  = 8'h00;
         m_pend  = 8'h00;
         m_ptr   = 0;
         m_grant = -1;
         return;
      end
      if (m_grant >= 0) begin
         if (ack) begin
            cleared = m_grant;
            m_ptr   = (m_grant + 1) % 8;
            m_grant = -1;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            int j;
            j = (m_ptr + i) % 8;
            if (m_grant < 0 && m_pend[j]) m_grant = j;
         end
      end
      if (cleared >= 0) m_pend[cleared] = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (req[b] && !m_prev[b]) m_pend[b] = 1'b1;
      end
      m_prev = req;
   endtask

   task automatic cyc(input logic [7:0] r, input logic k);
      req = r;
      ack = k;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(8'h00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [7:0] ea, input logic ee,
                       input logic [7:0] ep);
      chk({tag, ".a"}, a, ea);
      chk({tag, ".enable"}, {7'b0, enable}, {7'b0, ee});
      chk({tag, ".pending"}, pending, ep);
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] exp_a;

      rst = 1'b1;
      req = 8'h00;
      ack = 1'b0;
      model_step();
      @(posedge clk);
      #1;
      cyc(8'h00, 1'b0);
      rst = 1'b0;
      chk3("reset", 8'h00, 1'b0, 8'h00);

      // Single pulse on bit 2, then fairness from ptr=3 with bits 1 and 5.
      vecs[0] = '{8'h04, 1'b0, 8'h00, 1'b0, 8'h04};
      vecs[1] = '{8'h00, 1'b0, 8'h04, 1'b1, 8'h04};
      vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[4] = '{8'h22, 1'b0, 8'h00, 1'b0, 8'h22};
      vecs[5] = '{8'h00, 1'b0, 8'h20, 1'b1, 8'h22};
      vecs[6] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h02};
      vecs[7] = '{8'h00, 1'b0, 8'h02, 1'b1, 8'h02};
      vecs[8] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      vecs[9] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
      for (int i = 0; i < 10; i++) begin
         cyc(vecs[i].req, vecs[i].ack);
         chk3($sformatf("vec%0d", i), vecs[i].a, vecs[i].en, vecs[i].pend);
      end

      // Simultaneous edges on bits 0 and 7 from ptr=0; held level re-requests nothing.
      do_reset();
      cyc(8'h81, 1'b0); chk3("sim.c0", 8'h00, 1'b0, 8'h81);
      cyc(8'h81, 1'b0); chk3("sim.c1", 8'h01, 1'b1, 8'h81);
      cyc(8'h81, 1'b1); chk3("sim.c2", 8'h00, 1'b0, 8'h80);
      cyc(8'h81, 1'b0); chk3("sim.c3", 8'h80, 1'b1, 8'h80);
      cyc(8'h81, 1'b1); chk3("sim.c4", 8'h00, 1'b0, 8'h00);
      cyc(8'h81, 1'b0); chk3("sim.c5", 8'h00, 1'b0, 8'h00);

      // Ack withheld for 10 cycles; edge on bit 6 accumulates meanwhile.
      do_reset();
      cyc(8'h01, 1'b0);
      cyc(8'h00, 1'b0); chk3("hold.g", 8'h01, 1'b1, 8'h01);
      for (int i = 0; i < 10; i++) begin
         cyc((i == 4) ? 8'h40 : 8'h00, 1'b0);
         chk($sformatf("hold.a%0d", i), a, 8'h01);
         chk($sformatf("hold.en%0d", i), {7'b0, enable}, 8'h01);
      end
      chk("hold.pending", pending, 8'h41);
      cyc(8'h00, 1'b1); chk3("hold.ack", 8'h00, 1'b0, 8'h40);
      // ack while IDLE: bit 6 still granted, nothing cleared.
      cyc(8'h00, 1'b1); chk3("hold.idleack", 8'h40, 1'b1, 8'h40);
      cyc(8'h00, 1'b1); chk3("hold.ack2", 8'h00, 1'b0, 8'h00);

      // Collision: bit 3 re-rises on the ack cycle and stays pending.
      do_reset();
      cyc(8'h08, 1'b0);
      cyc(8'h08, 1'b0); chk3("col.g", 8'h08, 1'b1, 8'h08);
      cyc(8'h00, 1'b0);
      cyc(8'h08, 1'b1); chk3("col.ack", 8'h00, 1'b0, 8'h08);
      cyc(8'h08, 1'b0); chk3("col.regrant", 8'h08, 1'b1, 8'h08);

      // Reset mid-grant; request held through reset re-arrives as an edge.
      do_reset();
      cyc(8'h30, 1'b0);
      cyc(8'h30, 1'b0); chk3("rmg.g", 8'h10, 1'b1, 8'h30);
      rst = 1'b1;
      cyc(8'h30, 1'b0);
      rst = 1'b0;
      chk3("rmg.rst", 8'h00, 1'b0, 8'h00);
      cyc(8'h30, 1'b0); chk3("rmg.c1", 8'h00, 1'b0, 8'h30);
      cyc(8'h30, 1'b0); chk3("rmg.c2", 8'h10, 1'b1, 8'h30);

      // Random traffic against the model.
      do_reset();
      r = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 249) == 0);
         r   = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         cyc(r, ($urandom_range(0, 2) == 0));
         rst   = 1'b0;
         exp_a = (m_grant >= 0) ? 8'(1 << m_grant) : 8'h00;
         chk3($sformatf("rnd%0d", i), exp_a, (m_grant >= 0), m_pend);
         chk($sformatf("rnd%0d.onehot", i), {7'b0, ($countones(a) <= 1)}, 8'h01);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
